// File: rtl/mul_sequencer_if.sv
// Operand, adder and result signals shared by mul_sequencer and its environment.
// The master side supplies operands and closes the loop through the shared adder;
// the slave side is the sequencer.
interface mul_sequencer_if #(
  parameter int unsigned WORD = 64
);
  logic            start;
  logic [WORD-1:0] multiplicand;
  logic [WORD-1:0] multiplier;
  logic [WORD-1:0] add_a;
  logic [WORD-1:0] add_b;
  logic [WORD-1:0] add_sum;
  logic            busy;
  logic            done;
  logic [WORD-1:0] product;

  modport master (
    output start, multiplicand, multiplier, add_sum,
    input  add_a, add_b, busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier, add_sum,
    output add_a, add_b, busy, done, product
  );
endinterface

// File: rtl/mul_sequencer.sv
// Shift-and-add multiplier controller driving an external shared adder.
// Fixed latency of WORD iterations; yields the low WORD bits of the product.
module mul_sequencer #(
  parameter int unsigned WORD = 64
) (
  input logic            clk,
  input logic            reset,
  mul_sequencer_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WORD) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [WORD-1:0] m_q, m_d;
  logic [WORD-1:0] q_q, q_d;
  logic [WORD-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and datapath registers; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: load on start, iterate WORD times, one DONE cycle.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          m_d     = bus.multiplicand;
          q_d     = bus.multiplier;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Adder sees acc + M this cycle; keep it only when the current multiplier bit is set.
        if (q_q[0]) begin
          acc_d = bus.add_sum;
        end
        m_d   = m_q << 1;
        q_d   = q_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WORD - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs: adder operands only driven while iterating, product is always the accumulator.
  always_comb begin
    bus.busy    = (state_q == StRun);
    bus.done    = (state_q == StDone);
    bus.product = acc_q;
    bus.add_a   = '0;
    bus.add_b   = '0;
    if (state_q == StRun) begin
      bus.add_a = acc_q;
      bus.add_b = m_q;
    end
  end
endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: cycle-accurate arithmetic model plus directed cases.
module tb_mul_sequencer;
  localparam int unsigned WORD = 64;
  localparam int          LAT  = WORD + 1;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  mul_sequencer_if #(.WORD(WORD)) bus ();

  mul_sequencer #(.WORD(WORD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // The shared adder that the sequencer borrows.
  assign bus.add_sum = bus.add_a + bus.add_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WORD-1:0] act, input logic [WORD-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = idle, 1..WORD = iteration k, WORD+1 = completion cycle.
  int              ph;
  logic [WORD-1:0] ma, mb, mprod;
  logic            model_on;

  always @(posedge clk) begin
    logic [WORD-1:0] low;
    logic [WORD-1:0] e_prod, e_a, e_b;
    if (reset) begin
      ph       = 0;
      mprod    = '0;
      model_on = 1'b1;
    end else if (ph == 0) begin
      if (bus.start) begin
        ma    = bus.multiplicand;
        mb    = bus.multiplier;
        mprod = '0;
        ph    = 1;
      end
    end else if (ph <= WORD) begin
      ph++;
      if (ph == WORD + 1) mprod = ma * mb;
    end else begin
      ph = 0;
    end
    #1;
    if (model_on) begin
      e_prod = mprod;
      e_a    = '0;
      e_b    = '0;
      if (ph >= 1 && ph <= WORD) begin
        // After k-1 iterations the accumulator holds a times the low k-1 bits of b.
        low    = mb & ((64'd1 << (ph - 1)) - 64'd1);
        e_prod = ma * low;
        e_a    = e_prod;
        e_b    = ma << (ph - 1);
      end
      chk("model_busy", {63'd0, bus.busy}, {63'd0, (ph >= 1 && ph <= WORD)});
      chk("model_done", {63'd0, bus.done}, {63'd0, (ph == WORD + 1)});
      chk("model_product", bus.product, e_prod);
      chk("model_add_a", bus.add_a, e_a);
      chk("model_add_b", bus.add_b, e_b);
    end
  end

  // Run one operation from idle and pin latency, busy length and result with literals.
  task automatic do_op(input logic [WORD-1:0] a, input logic [WORD-1:0] b,
                       input logic [WORD-1:0] exp, input string name);
    int n;
    int nbusy;
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    @(posedge clk);
    #1;
    bus.start        = 1'b0;
    bus.multiplicand = $urandom;
    bus.multiplier   = $urandom;
    chk({name, "_first_add_a"}, bus.add_a, '0);
    chk({name, "_first_add_b"}, bus.add_b, a);
    n     = 1;
    nbusy = bus.busy ? 1 : 0;
    while (!bus.done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.busy) nbusy++;
    end
    chk({name, "_latency"}, 64'(n), 64'(LAT));
    chk({name, "_busy_cycles"}, 64'(nbusy), 64'(WORD));
    chk({name, "_product"}, bus.product, exp);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk({name, "_held"}, bus.product, exp);
    end
  endtask

  initial begin
    int n;
    tests            = 0;
    fails            = 0;
    model_on         = 1'b0;
    ph               = 0;
    ma               = '0;
    mb               = '0;
    mprod            = '0;
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {63'd0, bus.busy}, 64'd0);
    chk("reset_done", {63'd0, bus.done}, 64'd0);
    chk("reset_product", bus.product, 64'd0);
    chk("reset_add_b", bus.add_b, 64'd0);
    reset = 1'b0;

    do_op(64'd5, 64'd10, 64'd50, "t1");
    do_op(64'd280, -64'sd1000, -64'sd280000, "t2");
    do_op(-64'sd1000, 64'd280, -64'sd280000, "t2_swap");
    do_op(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, "zero_x_ones");
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, "ones_x_ones");
    do_op(64'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, "one_x_msb");
    do_op(64'd2, 64'h8000_0000_0000_0000, 64'd0, "two_x_msb_wrap");

    // Starts during RUN and DONE must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 64'd3; bus.multiplier = 64'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 64'd9; bus.multiplier = 64'd9;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ign_done_seen", {63'd0, bus.done}, 64'd1);
    chk("ign_product", bus.product, 64'd21);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("ign_idle_busy", {63'd0, bus.busy}, 64'd0);
      chk("ign_idle_done", {63'd0, bus.done}, 64'd0);
      chk("ign_idle_product", bus.product, 64'd21);
    end

    // Start held high: accepted at the first idle edge.
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 64'd6; bus.multiplier = 64'd7;
    n = 0;
    while (!bus.done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus.start = 1'b0;
    chk("held_latency", 64'(n), 64'(LAT));
    chk("held_product", bus.product, 64'd42);

    // Reset in the middle of an iteration aborts it.
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 64'd12; bus.multiplier = 64'd12;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (29) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("abort_done", {63'd0, bus.done}, 64'd0);
    chk("abort_product", bus.product, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op(64'd12, 64'd12, 64'd144, "after_abort");

    // Reset coincident with start: not accepted.
    @(negedge clk);
    reset = 1'b1; bus.start = 1'b1; bus.multiplicand = 64'd4; bus.multiplier = 64'd4;
    @(negedge clk);
    reset = 1'b0; bus.start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_start_busy", {63'd0, bus.busy}, 64'd0);
    end
    do_op(64'd4, 64'd4, 64'd16, "after_rst_start");

    // Random traffic: sporadic starts, operand churn and rare resets, checked by the model.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      bus.start        = ($urandom_range(0, 7) == 0);
      bus.multiplicand = {$urandom, $urandom};
      bus.multiplier   = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) bus.multiplier = 64'($urandom_range(0, 255));
      reset            = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
Multi-cycle shift-and-add multiplier controller that sequences the shared `adder` datapath block. The block does not contain its own adder. It drives the adder's a_in and b_in, and takes its add_out back to accumulate partial products. It produces the low WORD bits of an unsigned/two's-complement product, as required by LEGv8 MUL. It sits beside the EX stage and stalls it via busy.

Parameters:
WORD, 64, operand/product width; must equal `WORD of the attached adder.
CNT_W, $clog2(WORD)+1, iteration counter width (derived, not overridden).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
multiplicand  input  WORD  operand A; latched on accepted start
multiplier  input  WORD  operand B; latched on accepted start
add_a  output  WORD  to adder a_in
add_b  output  WORD  to adder b_in
add_sum  input  WORD  from adder add_out (combinational)
busy  output  1  high while iterating
done  output  1  one-cycle completion pulse
product  output  WORD  low WORD bits of multiplicand*multiplier

Behaviour:
- Interface timing: one clock, clk; reset is synchronous and active-high, honoured on any rising edge regardless of state.
- Internal registers:
  - state (IDLE, RUN, DONE)
  - M (WORD, shifted multiplicand)
  - Q (WORD, shifted multiplier)
  - acc (WORD)
  - cnt (CNT_W)
- Reset values: state=IDLE, M=Q=acc=0, cnt=0. Outputs: busy=0, done=0, product=0, add_a=0, add_b=0.
- IDLE:
  - start=1 at an edge: M<=multiplicand, Q<=multiplier, acc<=0, cnt<=0, state<=RUN.
  - start=0: hold all registers.
- RUN, each edge:
  - If Q[0]=1, acc<=add_sum; otherwise acc holds.
  - M<=M<<1 (zero fill, MSB discarded).
  - Q<=Q>>1 (logical).
  - cnt<=cnt+1.
  - When cnt==WORD-1 on this edge, state<=DONE.
- RUN latency: exactly WORD iterations. There is no early exit on Q==0, so latency is fixed.
- DONE: lasts one cycle, then state<=IDLE unconditionally.
- Outputs:
  - busy=1 iff state==RUN.
  - done=1 iff state==DONE.
  - product=acc at all times. Valid when done=1, and held through IDLE until the next accepted start clears acc.
- Adder drive:
  - RUN: add_a=acc, add_b=M.
  - IDLE and DONE: add_a=0, add_b=0.
- Total latency: start accepted at edge E0 → done high in the cycle after edge E0+WORD (WORD+1 cycles after acceptance) → back in IDLE after E0+WORD+1.
- Arithmetic: all sums wrap modulo 2^WORD; carry-out is discarded. Signed operands yield the correct low WORD bits with no special handling.
- start while RUN or DONE: ignored. The in-flight operation is unaffected and operand inputs are not re-latched.
- start held high continuously: a new operation is accepted in the first IDLE cycle after DONE. Back-to-back throughput is therefore one result per WORD+2 cycles.
- Operand inputs may change freely after acceptance.
- Reset mid-RUN: abort. Next cycle is IDLE with product=0, no done pulse, busy=0.
- Reset coincident with start: reset wins and the operation is not accepted.

Test Plan (WORD=64):
1. Reset, then start with multiplicand=5, multiplier=10.
   - First RUN cycle: add_a=0, add_b=5.
   - busy=1 for 64 cycles; done pulses exactly once at cycle 65 after acceptance.
   - product=50, still 50 for 3 further IDLE cycles.
2. multiplicand=280, multiplier=-1000 (two's complement) → product=-280000. Repeat with operands swapped → same result and same latency.
3. Boundaries:
   - 0 × 0xFFFF_FFFF_FFFF_FFFF → 0.
   - 0xFFFF_FFFF_FFFF_FFFF × 0xFFFF_FFFF_FFFF_FFFF → 1.
   - 1×0x8000_0000_0000_0000 → 0x8000_0000_0000_0000.
   - 2×0x8000_0000_0000_0000 → 0 (wrap).
4. Start 3×7, pulse start with 9×9 at RUN cycle 10 and again during DONE. Both new starts are ignored; result is 21, one done pulse. Then hold start high with 6×7: accepted in the next IDLE cycle → 42 after another 65 cycles.
5. Start 12×12, assert reset at RUN cycle 30 for one cycle.
   - Next cycle: IDLE, busy=0, product=0, no done.
   - Then 12×12 → 144 with normal latency.
6. Assert reset and start in the same cycle → no busy afterwards. A following start with 4×4 → 16.
